// File: rtl/vfm_shared_bus_arbiter.sv
// Round-robin arbiter sharing one I/O / data-memory bus among the RISC cores.
// One owner at a time, with a hold-time limit and a dead cycle after every release.
module vfm_shared_bus_arbiter #(
   parameter int N_CORES = 4,
   parameter int ADDR_W  = 14,
   parameter int DATA_W  = 14,
   parameter int TIMEOUT = 16
) (
   input  logic                        Clock_pin,
   input  logic                        Resetn_pin,
   input  logic [N_CORES-1:0]          Req,
   input  logic [N_CORES-1:0]          Rel,
   input  logic [N_CORES*ADDR_W-1:0]   Addr_in,
   input  logic [N_CORES*DATA_W-1:0]   Data_in,
   input  logic [N_CORES-1:0]          We_in,
   output logic [N_CORES-1:0]          Gnt,
   output logic [$clog2(N_CORES)-1:0]  Owner,
   output logic [ADDR_W-1:0]           Bus_addr,
   output logic [DATA_W-1:0]           Bus_data,
   output logic                        Bus_we,
   output logic                        Bus_valid,
   output logic                        Timeout_err
);

   localparam int OW = $clog2(N_CORES);
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RECOVER = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [N_CORES-1:0]   gnt_q, gnt_d;
   logic [OW-1:0]        owner_q, owner_d;
   logic [OW-1:0]        ptr_q, ptr_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 tout_q, tout_d;

   logic [OW-1:0]        pick;
   logic                 any_req;
   logic [OW:0]          idx;
   logic [OW-1:0]        ptr_after;
   logic                 bus_valid;

   logic [ADDR_W-1:0]    addr_arr [N_CORES];
   logic [DATA_W-1:0]    data_arr [N_CORES];

   for (genvar gi = 0; gi < N_CORES; gi++) begin : g_unpack
      assign addr_arr[gi] = Addr_in[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = Data_in[gi*DATA_W +: DATA_W];
   end

   // Scan from the highest offset down so the lowest offset from ptr_q wins.
   always_comb begin
      pick    = '0;
      any_req = 1'b0;
      idx     = '0;
      for (int i = N_CORES - 1; i >= 0; i--) begin
         idx = {1'b0, ptr_q} + (OW+1)'(i);
         if (idx >= (OW+1)'(N_CORES)) begin
            idx = idx - (OW+1)'(N_CORES);
         end
         if (Req[idx[OW-1:0]]) begin
            pick    = idx[OW-1:0];
            any_req = 1'b1;
         end
      end
   end

   assign ptr_after = (owner_q == OW'(N_CORES - 1)) ? '0 : owner_q + 1'b1;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      tout_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d     = ST_GRANT;
               gnt_d       = '0;
               gnt_d[pick] = 1'b1;
               owner_d     = pick;
               cnt_d       = '0;
            end
         end
         ST_GRANT: begin
            // A real release outranks the timeout when both land together.
            if (Rel[owner_q] || !Req[owner_q]) begin
               state_d = ST_RECOVER;
               gnt_d   = '0;
               ptr_d   = ptr_after;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d = ST_RECOVER;
               gnt_d   = '0;
               ptr_d   = ptr_after;
               tout_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RECOVER: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
      if (!Resetn_pin) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         tout_q  <= tout_d;
      end
   end

   // Bus side is combinational from the owner's port, forced to zero outside GRANT.
   assign bus_valid   = (state_q == ST_GRANT);
   assign Bus_valid   = bus_valid;
   assign Bus_we      = bus_valid & We_in[owner_q];
   assign Bus_addr    = bus_valid ? addr_arr[owner_q] : '0;
   assign Bus_data    = bus_valid ? data_arr[owner_q] : '0;
   assign Gnt         = gnt_q;
   assign Owner       = owner_q;
   assign Timeout_err = tout_q;

   a_gnt_onehot : assert property (@(posedge Clock_pin) disable iff (!Resetn_pin)
      $onehot0(gnt_q));
   a_gnt_only_in_grant : assert property (@(posedge Clock_pin) disable iff (!Resetn_pin)
      (state_q != ST_GRANT) |-> (gnt_q == '0));

endmodule

// File: tb/tb_vfm_shared_bus_arbiter.sv
// Directed bench for vfm_shared_bus_arbiter: a vector table plus hand-written
// sequences for round-robin order, timeout, late release and mid-grant reset.
module tb_vfm_shared_bus_arbiter;

   logic        clk;
   logic        Resetn_pin;
   logic [3:0]  Req, Rel, We_in;
   logic [55:0] Addr_in, Data_in;
   logic [3:0]  Gnt;
   logic [1:0]  Owner;
   logic [13:0] Bus_addr, Bus_data;
   logic        Bus_we, Bus_valid, Timeout_err;

   int n_tests = 0;
   int n_fail  = 0;

   vfm_shared_bus_arbiter #(
      .N_CORES(4), .ADDR_W(14), .DATA_W(14), .TIMEOUT(16)
   ) dut (
      .Clock_pin   (clk),
      .Resetn_pin  (Resetn_pin),
      .Req         (Req),
      .Rel         (Rel),
      .Addr_in     (Addr_in),
      .Data_in     (Data_in),
      .We_in       (We_in),
      .Gnt         (Gnt),
      .Owner       (Owner),
      .Bus_addr    (Bus_addr),
      .Bus_data    (Bus_data),
      .Bus_we      (Bus_we),
      .Bus_valid   (Bus_valid),
      .Timeout_err (Timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  req, rel, we;
      logic [3:0]  gnt;
      logic [1:0]  own;
      logic        v, bwe;
      logic [13:0] a, d;
      logic        to;
   } vec_t;

   vec_t vt [14];

   function automatic vec_t mk(input logic [3:0] req, input logic [3:0] rel,
                               input logic [3:0] we, input logic [3:0] gnt,
                               input logic [1:0] own, input logic v, input logic bwe,
                               input logic [13:0] a, input logic [13:0] d,
                               input logic to);
      vec_t r;
      r.req = req; r.rel = rel; r.we = we; r.gnt = gnt; r.own = own;
      r.v = v; r.bwe = bwe; r.a = a; r.d = d; r.to = to;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      Resetn_pin = 1'b0;
      Req = '0; Rel = '0; We_in = '0;
      repeat (2) step();
      chk({tag, "_gnt"},   32'(Gnt), 32'h0);
      chk({tag, "_owner"}, 32'(Owner), 32'h0);
      chk({tag, "_valid"}, 32'(Bus_valid), 32'h0);
      chk({tag, "_we"},    32'(Bus_we), 32'h0);
      chk({tag, "_addr"},  32'(Bus_addr), 32'h0);
      chk({tag, "_data"},  32'(Bus_data), 32'h0);
      chk({tag, "_tout"},  32'(Timeout_err), 32'h0);
      Resetn_pin = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_own [5];
      int dead;
      int hi;
      bit seen;

      Addr_in = {14'h3FFF, 14'h2AA2, 14'h1155, 14'h0012};
      Data_in = {14'h3456, 14'h2345, 14'h1234, 14'h0ABC};

      //           req    rel    we     gnt    own v  bwe addr     data     to
      vt[0]  = mk(4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 0, 0, 14'h0,    14'h0,    0);
      vt[1]  = mk(4'h1, 4'h0, 4'h1, 4'h1, 2'd0, 1, 1, 14'h0012, 14'h0ABC, 0);
      vt[2]  = mk(4'h1, 4'h1, 4'h1, 4'h0, 2'd0, 0, 0, 14'h0,    14'h0,    0);
      vt[3]  = mk(4'h1, 4'h0, 4'h1, 4'h0, 2'd0, 0, 0, 14'h0,    14'h0,    0);
      vt[4]  = mk(4'h1, 4'h0, 4'h0, 4'h1, 2'd0, 1, 0, 14'h0012, 14'h0ABC, 0);
      vt[5]  = mk(4'h0, 4'h0, 4'h1, 4'h0, 2'd0, 0, 0, 14'h0,    14'h0,    0);
      vt[6]  = mk(4'h3, 4'h0, 4'h0, 4'h0, 2'd0, 0, 0, 14'h0,    14'h0,    0);
      vt[7]  = mk(4'h3, 4'h0, 4'h2, 4'h2, 2'd1, 1, 1, 14'h1155, 14'h1234, 0);
      vt[8]  = mk(4'h3, 4'h8, 4'h0, 4'h2, 2'd1, 1, 0, 14'h1155, 14'h1234, 0);
      vt[9]  = mk(4'h3, 4'h1, 4'h3, 4'h2, 2'd1, 1, 1, 14'h1155, 14'h1234, 0);
      vt[10] = mk(4'h1, 4'h0, 4'h0, 4'h0, 2'd1, 0, 0, 14'h0,    14'h0,    0);
      vt[11] = mk(4'h1, 4'h0, 4'h0, 4'h0, 2'd1, 0, 0, 14'h0,    14'h0,    0);
      vt[12] = mk(4'h1, 4'h0, 4'h1, 4'h1, 2'd0, 1, 1, 14'h0012, 14'h0ABC, 0);
      vt[13] = mk(4'h1, 4'h1, 4'h0, 4'h0, 2'd0, 0, 0, 14'h0,    14'h0,    0);

      do_reset("rst0");

      for (int i = 0; i < 14; i++) begin
         Req = vt[i].req; Rel = vt[i].rel; We_in = vt[i].we;
         step();
         chk($sformatf("vec%0d_gnt", i),   32'(Gnt),         32'(vt[i].gnt));
         chk($sformatf("vec%0d_owner", i), 32'(Owner),       32'(vt[i].own));
         chk($sformatf("vec%0d_valid", i), 32'(Bus_valid),   32'(vt[i].v));
         chk($sformatf("vec%0d_we", i),    32'(Bus_we),      32'(vt[i].bwe));
         chk($sformatf("vec%0d_addr", i),  32'(Bus_addr),    32'(vt[i].a));
         chk($sformatf("vec%0d_data", i),  32'(Bus_data),    32'(vt[i].d));
         chk($sformatf("vec%0d_tout", i),  32'(Timeout_err), 32'(vt[i].to));
         $display("[TB] vec%0d req=%h rel=%h we=%h -> gnt=%h owner=%0d valid=%b",
                  i, Req, Rel, We_in, Gnt, Owner, Bus_valid);
      end

      // Round robin with all cores requesting, each releasing after 3 cycles.
      do_reset("rst1");
      exp_own = '{0, 1, 2, 3, 0};
      Req = 4'hF; We_in = '0;
      dead = 0;
      for (int g = 0; g < 5; g++) begin
         seen = 1'b0;
         for (int c = 0; c < 10 && !seen; c++) begin
            step();
            if (Gnt != 4'h0) seen = 1'b1;
            else dead++;
         end
         chk($sformatf("rr%0d_seen", g),  32'(seen), 32'h1);
         chk($sformatf("rr%0d_gnt", g),   32'(Gnt), 32'(4'h1 << exp_own[g]));
         chk($sformatf("rr%0d_owner", g), 32'(Owner), 32'(exp_own[g]));
         chk($sformatf("rr%0d_dead", g),  32'(dead), (g == 0) ? 32'h0 : 32'h2);
         $display("[TB] rr grant %0d -> core %0d after %0d dead cycles", g, Owner, dead);
         repeat (2) step();
         Rel = 4'h1 << Owner;
         step();
         Rel = '0;
         dead = (Gnt == 4'h0) ? 1 : 0;
      end

      // Forced release after TIMEOUT cycles of holding.
      do_reset("rst2");
      Req = 4'h4;
      step();
      chk("to_first_gnt", 32'(Gnt), 32'h4);
      hi = 1;
      for (int c = 0; c < 40; c++) begin
         step();
         if (Gnt == 4'h4) hi++;
         else break;
      end
      chk("to_hold_cycles", 32'(hi), 32'd16);
      chk("to_gnt_drop", 32'(Gnt), 32'h0);
      chk("to_err_pulse", 32'(Timeout_err), 32'h1);
      $display("[TB] timeout: held %0d cycles, Timeout_err=%b", hi, Timeout_err);
      step();
      chk("to_err_clear", 32'(Timeout_err), 32'h0);
      chk("to_idle_gnt", 32'(Gnt), 32'h0);
      step();
      chk("to_regrant_core2", 32'(Gnt), 32'h4);
      Req = 4'h5; Rel = 4'h4;
      step();
      Rel = '0;
      chk("to_rel_gnt", 32'(Gnt), 32'h0);
      chk("to_rel_noerr", 32'(Timeout_err), 32'h0);
      step();
      step();
      chk("to_other_wins", 32'(Gnt), 32'h1);
      $display("[TB] after release with req=0101 -> gnt=%h", Gnt);

      // Release coinciding with counter==TIMEOUT-1; non-owner Rel ignored.
      do_reset("rst3");
      Req = 4'h8;
      step();
      chk("late_gnt", 32'(Gnt), 32'h8);
      Rel = 4'h2;
      step();
      Rel = '0;
      chk("late_nonowner_rel", 32'(Gnt), 32'h8);
      repeat (14) step();
      chk("late_still_held", 32'(Gnt), 32'h8);
      Rel = 4'h8;
      step();
      Rel = '0;
      chk("late_rel_gnt", 32'(Gnt), 32'h0);
      chk("late_rel_noerr", 32'(Timeout_err), 32'h0);
      $display("[TB] release at last cycle -> gnt=%h Timeout_err=%b", Gnt, Timeout_err);

      // Owner dropping Req acts as release; pointer moves past it.
      do_reset("rst4");
      Req = 4'h4;
      step();
      chk("drop_gnt2", 32'(Gnt), 32'h4);
      Req = 4'h3;
      step();
      chk("drop_recover", 32'(Gnt), 32'h0);
      chk("drop_noerr", 32'(Timeout_err), 32'h0);
      step();
      step();
      chk("drop_next_gnt", 32'(Gnt), 32'h1);
      chk("drop_next_owner", 32'(Owner), 32'h0);
      $display("[TB] drop-req release -> gnt=%h owner=%0d", Gnt, Owner);

      // Asynchronous reset in the middle of a write grant.
      do_reset("rst5");
      Req = 4'h1; We_in = 4'h1;
      step();
      chk("ar_pre_we", 32'(Bus_we), 32'h1);
      #2 Resetn_pin = 1'b0;
      #1;
      chk("ar_gnt", 32'(Gnt), 32'h0);
      chk("ar_we", 32'(Bus_we), 32'h0);
      chk("ar_valid", 32'(Bus_valid), 32'h0);
      $display("[TB] async reset mid-grant -> gnt=%h we=%b valid=%b", Gnt, Bus_we, Bus_valid);
      step();
      step();
      Resetn_pin = 1'b1;
      Req = 4'hA; We_in = '0;
      step();
      chk("ar_first_gnt", 32'(Gnt), 32'h2);
      chk("ar_first_owner", 32'(Owner), 32'h1);
      $display("[TB] after reset req=1010 -> gnt=%h owner=%0d", Gnt, Owner);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vfm_shared_bus_arbiter.md
Name: vfm_shared_bus_arbiter

Overview:
- Round-robin arbiter that shares one I/O / data-memory bus among the vfmRISC621pipe_v cores of the multi-core system.
- Sits between the cores' external-access ports and the shared peripheral block, which holds the LED outputs and the dip-switch input register.
- Grants exactly one core at a time and muxes that core's address, data and write-enable onto the bus.
- Enforces a maximum hold time so a hung core cannot starve the others.

Parameters:
N_CORES, 4, number of requesting cores (2..8)
ADDR_W, 14, address width per core
DATA_W, 14, data width per core
TIMEOUT, 16, max cycles a grant may be held (>=2)

Ports:
Clock_pin  in  1  system clock, all state on rising edge
Resetn_pin  in  1  asynchronous active-low reset
Req  in  N_CORES  per-core bus request, level
Rel  in  N_CORES  per-core release pulse, 1 cycle
Addr_in  in  N_CORES*ADDR_W  per-core address, core i at [i*ADDR_W +: ADDR_W]
Data_in  in  N_CORES*DATA_W  per-core write data, same packing
We_in  in  N_CORES  per-core write enable
Gnt  out  N_CORES  one-hot grant, registered
Owner  out  clog2(N_CORES)  index of current/last owner, registered
Bus_addr  out  ADDR_W  muxed address
Bus_data  out  DATA_W  muxed write data
Bus_we  out  1  muxed write enable
Bus_valid  out  1  high while in GRANT
Timeout_err  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (async, Resetn_pin=0):
  - State IDLE; Gnt=0, Owner=0, Timeout_err=0, Bus_valid=0, Bus_we=0, Bus_addr=0, Bus_data=0.
  - Round-robin pointer=0, hold counter=0.
  - Reset mid-grant drops the grant immediately; no write issues in the reset cycle.
- FSM states: IDLE, GRANT, RECOVER.
- IDLE:
  - If any Req bit is set, pick the first set bit scanning upward from the pointer, wrapping modulo N_CORES.
  - Next cycle: state=GRANT, Gnt[k]=1, Owner=k, counter=0. Grant latency is 1 cycle from a sampled Req.
  - If Req=0, stay in IDLE.
- GRANT:
  - Counter increments each cycle.
  - Bus_valid=1.
  - Bus_addr/Bus_data/Bus_we come combinationally from core Owner's inputs.
  - Bus_we=We_in[Owner] gated by Bus_valid.
  - Exit to RECOVER on the first of:
    - Rel[Owner]=1;
    - Req[Owner]=0;
    - counter==TIMEOUT-1 with neither of the above (forced release).
  - Rel or Req from non-owners is ignored.
- Simultaneous Rel[Owner] and timeout: treated as a normal release, Timeout_err stays 0.
- Forced release: Timeout_err=1 for exactly the cycle in RECOVER.
- On exit to RECOVER, pointer = Owner+1 mod N_CORES, so the released core gets lowest priority.
- RECOVER:
  - One dead cycle: Gnt=0, Bus_valid=0, Bus_we=0, Bus_addr/Bus_data=0.
  - Then IDLE unconditionally. A new grant therefore appears at the earliest 2 cycles after release (RECOVER, IDLE, then GRANT).
- Owner holds its last value outside GRANT.
- Gnt is never more than one-hot; Gnt=0 whenever state is not GRANT.
- A Req still held by the released core is re-arbitrated normally; it wins only if no other core requests.

Test Plan:
- Reset then Req=4'b0001: Gnt=0001 one cycle later, Owner=0, Bus_valid=1; drive Addr_in core0=14'h0012, We_in[0]=1 -> Bus_addr=0012, Bus_we=1; Rel[0] pulse -> Gnt=0 next cycle, then Bus_valid=0.
- Req=4'b1111 held, each owner pulses Rel after 3 cycles: grant order 0,1,2,3,0, with exactly 2 idle cycles (RECOVER, IDLE) between grants.
- Req=4'b0100 held, no Rel, TIMEOUT=16: Gnt[2] high for exactly 16 cycles, then Timeout_err=1 for 1 cycle, Gnt=0; next grant goes to core 2 again only if no other Req is set.
- Rel[Owner] asserted on the cycle counter==15: release with Timeout_err=0; Rel[1] pulsed while core 3 is the owner: no effect.
- Owner core 2 deasserts Req with no Rel: treated as release, pointer becomes 3; with Req=4'b0011 pending, the next grant goes to core 0 (scan 3,0).
- Resetn_pin pulled low mid-GRANT with We_in=1: Gnt, Bus_we, Bus_valid drop to 0 asynchronously; after reset release with Req=4'b1010, the first grant goes to core 1.
